njesia_kontrollit: RTL and testbench
====================================

Name: njesia_kontrollit

Overview:
- Multicycle control FSM for the 16-bit CPU; sits directly upstream of the datapath 2:1 muxes and drives their select lines.
- Drives RegDst, ALUSrc and MemToReg, plus all register, PC and memory write enables.
- Sequences each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Stalls on a memory-ready handshake.

Parameters:
- WD_LIMIT, 15, number of consecutive stalled cycles before the watchdog trips; only used with CTRL_WATCHDOG_EN.
- WD_W, 4, width of the watchdog counter; must satisfy 2^WD_W > WD_LIMIT.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Opcode  input  4  IR[15:12], valid from the cycle after IRWrite.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- IRWrite  output  1  load the instruction register.
- PCWrite  output  1  load the PC.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  mux select: 1 = rd, 0 = rt.
- ALUSrc  output  1  mux select: 1 = immediate, 0 = register.
- MemToReg  output  1  mux select: 1 = memory data, 0 = ALU result.
- AluOp  output  2  00 = add, 01 = subtract, 10 = use funct field.
- Halted  output  1  FSM is in HALT.
- Gabim  output  1  watchdog error, sticky.

Behaviour:
- One clock domain (Clock). Reset is synchronous and active-high.
- Reset at a clock edge, including mid-instruction, forces state IDLE, clears op_q and clears the watchdog counter.
- All outputs are 0 while in IDLE.
- IDLE → FETCH unconditionally on the next edge.
- Outputs are decoded combinationally from the registered state and op_q. The only inputs that gate outputs are MemReady and Zero, as listed below.
- Opcode encoding:
  - 0000 = R-type
  - 0100 = ADDI
  - 1000 = LW
  - 1100 = SW
  - 0010 = BEQ
  - 1111 = HALT
  - any other value = NOP
- FETCH:
  - MemRead = 1.
  - IRWrite = MemReady and PCWrite = MemReady (PC + 2 happens in the datapath).
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE:
  - All outputs 0. Captures Opcode into op_q.
  - R-type, ADDI, LW, SW → EXEC.
  - BEQ → BRANCH.
  - HALT → HALT.
  - NOP → FETCH.
- EXEC:
  - ALUSrc = 1 for ADDI, LW and SW; ALUSrc = 0 for R-type.
  - AluOp = 10 for R-type, otherwise 00.
  - R-type and ADDI → WB; LW and SW → MEM.
- MEM:
  - MemRead = 1 for LW; MemWrite = 1 for SW. ALUSrc = 1 is held so the address stays stable.
  - Stays in MEM while MemReady = 0.
  - When MemReady = 1: LW → WB, SW → FETCH.
- WB:
  - RegWrite = 1.
  - RegDst = 1 only for R-type.
  - MemToReg = 1 only for LW.
  - → FETCH.
- BRANCH:
  - ALUSrc = 0, AluOp = 01, PCWrite = Zero.
  - → FETCH.
- HALT:
  - Halted = 1, all other outputs 0.
  - Stays in HALT until Reset.
- Instruction latency, counted from FETCH entry and assuming MemReady = 1 on the first cycle:
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - NOP: 2 cycles.
- MemRead and MemWrite are never high in the same cycle. Every extra cycle with MemReady = 0 adds exactly one cycle of latency.
- Opcode changes outside DECODE have no effect.

Optional Feature:
- Macro: CTRL_WATCHDOG_EN.
- When defined:
  - A WD_W-bit counter increments on each cycle spent in FETCH or MEM with MemReady = 0.
  - The counter clears on any cycle with MemReady = 1 and on any state change.
  - When the counter equals WD_LIMIT, the next state is ERROR.
  - In ERROR: Gabim = 1, all other outputs 0; stays in ERROR until Reset.
- When not defined:
  - The FSM waits on MemReady indefinitely.
  - Gabim is tied to 0 and the ERROR state does not exist.

Test Plan:
- Reset high for 2 cycles, then low, with MemReady = 1 → all outputs 0 in IDLE; next cycle FETCH with MemRead = 1, IRWrite = 1, PCWrite = 1.
- Opcode = 0000, MemReady = 1 → sequence FETCH, DECODE, EXEC, WB. EXEC shows AluOp = 10, ALUSrc = 0; WB shows RegWrite = 1, RegDst = 1, MemToReg = 0.
- Opcode = 1000, MemReady low for 3 MEM cycles → MEM lasts 4 cycles with MemRead = 1. WB then shows RegWrite = 1, MemToReg = 1, RegDst = 0. Total latency 8 cycles.
- Opcode = 0010: first with Zero = 1, then with Zero = 0 → BRANCH shows AluOp = 01, ALUSrc = 0. PCWrite = 1 only in the Zero = 1 case; FSM returns to FETCH in both cases.
- Opcode = 1100, Reset asserted in the MEM cycle → next cycle IDLE with MemWrite = 0; no RegWrite occurs. Separately, Opcode = 1111 → Halted = 1 held for 20 cycles.
- With CTRL_WATCHDOG_EN and WD_LIMIT = 15, MemReady held 0 in FETCH → Gabim = 1 after 16 stalled cycles, sticky until Reset. Without the macro, the FSM stays in FETCH and Gabim = 0.

Source files
------------

// File: rtl/njesia_kontrollit_if.sv
// Control bus between the multicycle control FSM and the datapath.
// master: the control FSM (consumes opcode/flags, drives selects and enables).
// slave : the datapath side (drives opcode/flags, consumes selects and enables).
interface njesia_kontrollit_if;
   logic [3:0] Opcode;
   logic       Zero;
   logic       MemReady;
   logic       IRWrite;
   logic       PCWrite;
   logic       MemRead;
   logic       MemWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       ALUSrc;
   logic       MemToReg;
   logic [1:0] AluOp;
   logic       Halted;
   logic       Gabim;

   modport master (
      input  Opcode, Zero, MemReady,
      output IRWrite, PCWrite, MemRead, MemWrite, RegWrite,
             RegDst, ALUSrc, MemToReg, AluOp, Halted, Gabim
   );

   modport slave (
      output Opcode, Zero, MemReady,
      input  IRWrite, PCWrite, MemRead, MemWrite, RegWrite,
             RegDst, ALUSrc, MemToReg, AluOp, Halted, Gabim
   );
endinterface

// File: rtl/njesia_kontrollit.sv
// Multicycle control FSM for the 16-bit CPU.
// Sequences FETCH / DECODE / EXEC / MEM / WB (plus BRANCH and HALT), stalling
// on MemReady. Outputs are decoded from the registered state and latched opcode.
// Optional memory-stall watchdog: define CTRL_WATCHDOG_EN to enable the ERROR
// state and the sticky Gabim flag; without it Gabim is tied low.
module njesia_kontrollit #(
   parameter int WD_LIMIT = 15,
   parameter int WD_W     = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   njesia_kontrollit_if.master   bus
);

   localparam logic [3:0] OP_R    = 4'b0000;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b1000;
   localparam logic [3:0] OP_SW   = 4'b1100;
   localparam logic [3:0] OP_BEQ  = 4'b0010;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_BRANCH,
      S_HALT
`ifdef CTRL_WATCHDOG_EN
      , S_ERROR
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;

`ifdef CTRL_WATCHDOG_EN
   logic [WD_W-1:0] wd_q, wd_d;
   logic            stalled;
`else
   // Watchdog parameters only matter when the watchdog is built in.
   localparam bit unused_wd_cfg = (WD_LIMIT < (1 << WD_W));
`endif

   // Next-state, opcode capture and watchdog count.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      unique case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            // op_q is not loaded yet, so the branch decision uses the live opcode.
            op_d = bus.Opcode;
            case (bus.Opcode)
               OP_R, OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC;
               OP_BEQ:                      state_d = S_BRANCH;
               OP_HALT:                     state_d = S_HALT;
               default:                     state_d = S_FETCH;
            endcase
         end
         S_EXEC:   state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
         S_MEM:    if (bus.MemReady) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
`ifdef CTRL_WATCHDOG_EN
         S_ERROR:  state_d = S_ERROR;
`endif
         default:  state_d = S_IDLE;
      endcase

`ifdef CTRL_WATCHDOG_EN
      // A stall keeps the state unchanged, so any non-stall cycle (ready or a
      // state change) clears the count.
      stalled = (state_q == S_FETCH || state_q == S_MEM) && !bus.MemReady;
      wd_d    = stalled ? wd_q + 1'b1 : '0;
      if (wd_q == WD_W'(WD_LIMIT)) state_d = S_ERROR;
`endif
   end

   // State, latched opcode and watchdog registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         op_q    <= 4'b0000;
`ifdef CTRL_WATCHDOG_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
`ifdef CTRL_WATCHDOG_EN
         wd_q    <= wd_d;
`endif
      end
   end

   // Control outputs decoded from state and op_q; only MemReady and Zero gate.
   always_comb begin
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst   = 1'b0;
      bus.ALUSrc   = 1'b0;
      bus.MemToReg = 1'b0;
      bus.AluOp    = ALU_ADD;
      bus.Halted   = 1'b0;
      bus.Gabim    = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC + 2 is applied by the datapath together with the IR load.
            bus.MemRead = 1'b1;
            bus.IRWrite = bus.MemReady;
            bus.PCWrite = bus.MemReady;
         end
         S_EXEC: begin
            bus.ALUSrc = (op_q != OP_R);
            bus.AluOp  = (op_q == OP_R) ? ALU_FUNCT : ALU_ADD;
         end
         S_MEM: begin
            // Keep the immediate selected so the address is stable while stalled.
            bus.ALUSrc   = 1'b1;
            bus.MemRead  = (op_q == OP_LW);
            bus.MemWrite = (op_q == OP_SW);
         end
         S_WB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = (op_q == OP_R);
            bus.MemToReg = (op_q == OP_LW);
         end
         S_BRANCH: begin
            bus.AluOp   = ALU_SUB;
            bus.PCWrite = bus.Zero;
         end
         S_HALT:  bus.Halted = 1'b1;
`ifdef CTRL_WATCHDOG_EN
         S_ERROR: bus.Gabim  = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_njesia_kontrollit.sv
// Randomized bench for njesia_kontrollit. The reference model keeps each
// instruction as a queue of pending phases (built at decode from the opcode)
// and compares the full control vector every cycle.
module tb_njesia_kontrollit;

   localparam int WD_LIMIT = 15;

   localparam logic [11:0] B_IRW  = 12'h800;
   localparam logic [11:0] B_PCW  = 12'h400;
   localparam logic [11:0] B_MRD  = 12'h200;
   localparam logic [11:0] B_MWR  = 12'h100;
   localparam logic [11:0] B_RGW  = 12'h080;
   localparam logic [11:0] B_RDST = 12'h040;
   localparam logic [11:0] B_ASRC = 12'h020;
   localparam logic [11:0] B_M2R  = 12'h010;
   localparam logic [11:0] B_ALUF = 12'h008;
   localparam logic [11:0] B_ALUS = 12'h004;
   localparam logic [11:0] B_HLT  = 12'h002;
   localparam logic [11:0] B_GAB  = 12'h001;

   typedef struct packed {
      logic [11:0] outs;
      logic        waits;   // held while MemReady = 0
      logic        gf;      // IRWrite/PCWrite follow MemReady
      logic        gz;      // PCWrite follows Zero
      logic        dec;     // opcode sampled when leaving
      logic        stay;    // terminal until reset
   } step_t;

   logic Clock;
   logic Reset;
   njesia_kontrollit_if bus ();

   njesia_kontrollit #(.WD_LIMIT(WD_LIMIT), .WD_W(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int    n_chk  = 0;
   int    n_fail = 0;
   step_t mq[$];
   int    stall  = 0;
   bit    mdl_valid = 0;
   string phase = "init";

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic step_t mk(input logic [11:0] o, input logic w, input logic gf,
                                input logic gz, input logic dec, input logic stay);
      step_t s;
      s.outs = o; s.waits = w; s.gf = gf; s.gz = gz; s.dec = dec; s.stay = stay;
      return s;
   endfunction

   function automatic logic [11:0] model_out(input logic mr, input logic z);
      step_t h = mq[0];
      logic [11:0] o = h.outs;
      if (h.gf && mr) o = o | B_IRW | B_PCW;
      if (h.gz && z)  o = o | B_PCW;
      return o;
   endfunction

   function automatic void advance(input logic rst, input logic [3:0] op, input logic mr);
      step_t h;
      if (rst) begin
         mq.delete();
         mq.push_back(mk(12'h0, 0, 0, 0, 0, 0));           // IDLE
         stall = 0;
         mdl_valid = 1;
         return;
      end
      if (!mdl_valid) return;
      h = mq[0];
`ifdef CTRL_WATCHDOG_EN
      if (h.waits && stall == WD_LIMIT) begin
         mq.delete();
         mq.push_back(mk(B_GAB, 0, 0, 0, 0, 1));
         stall = 0;
         return;
      end
`endif
      if (h.stay) return;
      if (h.waits && !mr) begin
         stall++;
         return;
      end
      stall = 0;
      void'(mq.pop_front());
      if (h.dec) begin
         case (op)
            4'b0000: begin
               mq.push_back(mk(B_ALUF, 0, 0, 0, 0, 0));
               mq.push_back(mk(B_RGW | B_RDST, 0, 0, 0, 0, 0));
            end
            4'b0100: begin
               mq.push_back(mk(B_ASRC, 0, 0, 0, 0, 0));
               mq.push_back(mk(B_RGW, 0, 0, 0, 0, 0));
            end
            4'b1000: begin
               mq.push_back(mk(B_ASRC, 0, 0, 0, 0, 0));
               mq.push_back(mk(B_MRD | B_ASRC, 1, 0, 0, 0, 0));
               mq.push_back(mk(B_RGW | B_M2R, 0, 0, 0, 0, 0));
            end
            4'b1100: begin
               mq.push_back(mk(B_ASRC, 0, 0, 0, 0, 0));
               mq.push_back(mk(B_MWR | B_ASRC, 1, 0, 0, 0, 0));
            end
            4'b0010: mq.push_back(mk(B_ALUS, 0, 0, 1, 0, 0));
            4'b1111: mq.push_back(mk(B_HLT, 0, 0, 0, 0, 1));
            default: ;
         endcase
      end
      if (mq.size() == 0) begin
         mq.push_back(mk(B_MRD, 1, 1, 0, 0, 0));           // FETCH
         mq.push_back(mk(12'h0, 0, 0, 0, 1, 0));           // DECODE
      end
   endfunction

   function automatic logic [11:0] dut_vec();
      return {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
              bus.RegDst, bus.ALUSrc, bus.MemToReg, bus.AluOp, bus.Halted, bus.Gabim};
   endfunction

   // One clock: drive, compare against the model, then advance it past the edge.
   task automatic cyc(input logic rst, input logic [3:0] op, input logic mr, input logic z);
      Reset        = rst;
      bus.Opcode   = op;
      bus.MemReady = mr;
      bus.Zero     = z;
      #4;
      if (mdl_valid) begin
         chk(phase, 32'(dut_vec()), 32'(model_out(mr, z)));
         chk("mem_rd_wr_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
      end
      @(posedge Clock);
      advance(rst, op, mr);
      #1;
   endtask

   task automatic drive(input logic rst, input logic [3:0] op, input logic mr,
                        input logic z, input int n);
      for (int i = 0; i < n; i++) cyc(rst, op, mr, z);
   endtask

   initial begin
      logic [3:0] ops [7];
      ops[0] = 4'b0000; ops[1] = 4'b0100; ops[2] = 4'b1000; ops[3] = 4'b1100;
      ops[4] = 4'b0010; ops[5] = 4'b1111; ops[6] = 4'b0110;

      phase = "reset";   drive(1, 4'b0000, 1, 0, 2);
      phase = "rtype";   drive(0, 4'b0000, 1, 0, 5);
      phase = "lw";      drive(0, 4'b1000, 1, 0, 3);
      phase = "lw_stall";drive(0, 4'b1000, 0, 0, 3);
      phase = "lw_wb";   drive(0, 4'b1000, 1, 0, 2);
      phase = "beq_z1";  drive(0, 4'b0010, 1, 1, 3);
      phase = "beq_z0";  drive(0, 4'b0010, 1, 0, 3);
      phase = "nop";     drive(0, 4'b0110, 1, 0, 2);
      phase = "sw";      drive(0, 4'b1100, 1, 0, 3);
      phase = "sw_rst";  drive(1, 4'b1100, 0, 0, 1);
      phase = "idle";    drive(0, 4'b1100, 1, 0, 1);
      phase = "halt";    drive(0, 4'b1111, 1, 0, 22);
      phase = "halt_rst";drive(1, 4'b0000, 1, 0, 1);
      phase = "stall";   drive(0, 4'b0000, 0, 0, 30);
      phase = "stall_rst"; drive(1, 4'b0000, 0, 0, 1);

      phase = "random";
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] op;
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
         cyc($urandom_range(0, 149) == 0, op, $urandom_range(0, 3) != 0, 1'($urandom));
      end

      phase = "final_rst"; drive(1, 4'b0000, 1, 0, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
